// File: rtl/loteria_sorteio.sv
// Five-digit lottery draw: a Galois LFSR is rejection-sampled to 0-9 and each
// digit is handed to a ready/insert receiver and latched onto a 7-segment display.
module loteria_sorteio #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter int unsigned GAP  = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        ready_i,
    input  logic        seed_load_i,
    input  logic [15:0] seed_i,
    output logic [3:0]  num_o,
    output logic        insert_o,
    output logic        finish_o,
    output logic        busy_o,
    output logic [3:0]  ledr_o,
    output logic [6:0]  hex0_o,
    output logic [6:0]  hex1_o,
    output logic [6:0]  hex2_o,
    output logic [6:0]  hex3_o,
    output logic [6:0]  hex4_o
);

    typedef enum logic [3:0] {
        StIdle = 4'd0,
        StDraw = 4'd1,
        StSend = 4'd2,
        StWait = 4'd3,
        StFin  = 4'd4
    } state_e;

    localparam logic [3:0] GapLast = 4'(GAP - 1);
    localparam logic [6:0] SegBlank = 7'b1111111;

    state_e      state_q;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_next;
    logic [2:0]  idx_q;
    logic [3:0]  num_q;
    logic [3:0]  gap_q;
    logic [6:0]  hex_q [5];

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SegBlank;
        endcase
    endfunction

    assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            lfsr_q  <= SEED;
            idx_q   <= 3'd0;
            num_q   <= 4'd0;
            gap_q   <= 4'd0;
            for (int i = 0; i < 5; i++) hex_q[i] <= SegBlank;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (seed_load_i) lfsr_q <= (seed_i == 16'h0000) ? SEED : seed_i;
                    if (start_i) begin
                        idx_q   <= 3'd0;
                        state_q <= StDraw;
                        for (int i = 0; i < 5; i++) hex_q[i] <= SegBlank;
                    end
                end
                StDraw: begin
                    // Advance on every draw cycle; out-of-range samples are simply retried.
                    lfsr_q <= lfsr_next;
                    if (lfsr_q[3:0] <= 4'd9) begin
                        num_q   <= lfsr_q[3:0];
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    if (ready_i) begin
                        hex_q[idx_q] <= seg7(num_q);
                        gap_q        <= 4'd0;
                        if (idx_q == 3'd4) begin
                            state_q <= StFin;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            state_q <= (GAP == 0) ? StDraw : StWait;
                        end
                    end
                end
                StWait: begin
                    if (gap_q == GapLast) state_q <= StDraw;
                    else gap_q <= gap_q + 4'd1;
                end
                StFin:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // insert is qualified by ready in the same cycle, so it cannot be a flop.
    assign insert_o = (state_q == StSend) && ready_i;
    assign finish_o = (state_q == StFin);
    assign busy_o   = (state_q != StIdle);
    assign ledr_o   = state_q;
    assign num_o    = num_q;
    assign hex4_o   = hex_q[0];
    assign hex3_o   = hex_q[1];
    assign hex2_o   = hex_q[2];
    assign hex1_o   = hex_q[3];
    assign hex0_o   = hex_q[4];

endmodule

// File: tb/tb_loteria_sorteio.sv
// Scoreboard bench for loteria_sorteio: stimulus queues expected digits,
// a negedge monitor pops and compares them on every insert strobe.
module tb_loteria_sorteio;

    logic        clk;
    logic        rst_n;
    logic        start, ready, seed_load;
    logic [15:0] seed;
    logic [3:0]  num, ledr;
    logic        insert, fin, busy;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4;

    logic        start_b;
    logic [3:0]  num_b, ledr_b;
    logic        insert_b, fin_b, busy_b;
    logic [6:0]  hb0, hb1, hb2, hb3, hb4;

    int n_chk = 0;
    int n_err = 0;
    int ins_cnt = 0, fin_cnt = 0, draw_cnt = 0;
    int i0, f0, d0;
    int cyc = 0;
    int b_ins = 0, b_fin = 0;
    int b_cyc [2];
    logic [3:0] b_num [2];
    logic [3:0] exp_q [$];

    localparam logic [34:0] HexExp = {7'b1111001, 7'b1000000, 7'b0000000, 7'b1111000, 7'b0110000};

    loteria_sorteio dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .ready_i(ready),
        .seed_load_i(seed_load), .seed_i(seed), .num_o(num), .insert_o(insert),
        .finish_o(fin), .busy_o(busy), .ledr_o(ledr), .hex0_o(hex0), .hex1_o(hex1),
        .hex2_o(hex2), .hex3_o(hex3), .hex4_o(hex4)
    );

    loteria_sorteio #(.GAP(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .ready_i(1'b1),
        .seed_load_i(1'b0), .seed_i(16'h0000), .num_o(num_b), .insert_o(insert_b),
        .finish_o(fin_b), .busy_o(busy_b), .ledr_o(ledr_b), .hex0_o(hb0), .hex1_o(hb1),
        .hex2_o(hb2), .hex3_o(hb3), .hex4_o(hb4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ledr == 4'd1) draw_cnt++;
        if (fin) fin_cnt++;
        if (insert) begin
            ins_cnt++;
            chk("insert_finish_exclusive", fin, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_insert", 1, 0);
            end else begin
                chk("num_on_insert", num, exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (insert_b) begin
            if (b_ins < 2) begin
                b_cyc[b_ins] = cyc;
                b_num[b_ins] = num_b;
            end
            b_ins++;
        end
        if (fin_b) b_fin++;
    end

    task automatic check_reset(input string tag);
        chk({tag, "_num"}, num, 0);
        chk({tag, "_insert"}, insert, 0);
        chk({tag, "_finish"}, fin, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ledr"}, ledr, 0);
        chk({tag, "_hex"}, {hex4, hex3, hex2, hex1, hex0}, {35{1'b1}});
    endtask

    task automatic load_seed(input logic [15:0] sd);
        @(posedge clk); #1;
        seed_load = 1'b1; seed = sd;
        @(posedge clk); #1;
        seed_load = 1'b0;
    endtask

    task automatic draw(input logic load, input logic [15:0] sd);
        i0 = ins_cnt; f0 = fin_cnt; d0 = draw_cnt;
        exp_q.delete();
        exp_q.push_back(4'd1); exp_q.push_back(4'd0); exp_q.push_back(4'd8);
        exp_q.push_back(4'd7); exp_q.push_back(4'd3);
        @(posedge clk); #1;
        start = 1'b1; seed_load = load; seed = sd;
        @(posedge clk); #1;
        start = 1'b0; seed_load = 1'b0;
    endtask

    task automatic finish_check(input string tag);
        bit seen = 0;
        for (int i = 0; i < 300; i++) begin
            if (fin_cnt != f0) begin
                seen = 1;
                break;
            end
            @(posedge clk);
        end
        chk({tag, "_finish_timeout"}, seen, 1);
        @(posedge clk); #1;
        chk({tag, "_finish_count"}, fin_cnt - f0, 1);
        chk({tag, "_insert_count"}, ins_cnt - i0, 5);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        chk({tag, "_draw_cycles"}, draw_cnt - d0, 7);
        chk({tag, "_hex"}, {hex4, hex3, hex2, hex1, hex0}, HexExp);
        chk({tag, "_idle"}, {busy, ledr}, 0);
    endtask

    initial begin
        bit hit;
        rst_n = 1'b1; start = 1'b0; ready = 1'b1; seed_load = 1'b0; seed = 16'h0;
        start_b = 1'b0;
        #3 rst_n = 1'b0;
        #1 check_reset("reset0");
        @(posedge clk); #1 rst_n = 1'b1;

        // Default seed draw, then the display must hold in IDLE.
        draw(1'b0, 16'h0);
        finish_check("default");
        repeat (3) @(posedge clk);
        #1;
        chk("idle_hold_num", num, 3);
        chk("idle_hold_hex", {hex4, hex3, hex2, hex1, hex0}, HexExp);

        load_seed(16'h0000);
        draw(1'b0, 16'h0);
        finish_check("seed_zero");

        draw(1'b1, 16'hACE1);
        finish_check("seed_with_start");

        // Receiver stalls in the first SEND.
        load_seed(16'h0000);
        ready = 1'b0;
        draw(1'b0, 16'h0);
        hit = 0;
        for (int i = 0; i < 20; i++) begin
            if (ledr == 4'd2) begin
                hit = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("stall_reach_send", hit, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_hold", {insert, num, ledr, busy}, {1'b0, 4'd1, 4'd2, 1'b1});
        end
        @(posedge clk); #1 ready = 1'b1;
        finish_check("stall");

        // Start pulse while waiting between digits is ignored.
        load_seed(16'h0000);
        draw(1'b0, 16'h0);
        hit = 0;
        for (int i = 0; i < 30; i++) begin
            if (ledr == 4'd3) begin
                hit = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("reach_wait", hit, 1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        finish_check("start_in_wait");

        // Reset during the third SEND aborts the draw.
        load_seed(16'h0000);
        draw(1'b0, 16'h0);
        hit = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (ins_cnt - i0 == 2 && ledr == 4'd2) begin
                hit = 1;
                break;
            end
        end
        chk("reach_third_send", hit, 1);
        #1 rst_n = 1'b0;
        #1 check_reset("midreset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("midreset_no_more_insert", ins_cnt - i0, 2);
        chk("midreset_no_finish", fin_cnt - f0, 0);
        draw(1'b0, 16'h0);
        finish_check("after_reset");

        // GAP=0 instance: digits 0 and 1 are two cycles apart.
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            if (b_fin != 0) begin
                hit = 1;
                break;
            end
            @(posedge clk);
        end
        chk("gap0_finish", hit, 1);
        @(posedge clk); #1;
        chk("gap0_inserts", b_ins, 5);
        chk("gap0_first_nums", {b_num[0], b_num[1]}, {4'd1, 4'd0});
        chk("gap0_spacing", b_cyc[1] - b_cyc[0], 2);
        chk("gap0_hex", {hb4, hb3, hb2, hb1, hb0}, HexExp);
        chk("gap0_idle", {busy_b, ledr_b}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/loteria_sorteio.md
LOTERIA_SORTEIO -- requirements
Module: loteria_sorteio

Interface
REQ-001 Parameter SEED, default 16'hACE1, LFSR value loaded at reset and substituted for any zero seed.
REQ-002 Parameter GAP, default 2, number of idle cycles between consecutive digit transfers (range 0-15).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begin a draw; sampled only in IDLE.
REQ-006 ready  input  1  receiver can accept a digit this cycle.
REQ-007 seed_load  input  1  load seed into the LFSR; honoured only in IDLE.
REQ-008 seed  input  16  seed value for seed_load.
REQ-009 num  output  4  drawn digit presented to the receiver, 0-9.
REQ-010 insert  output  1  one-cycle strobe: num is valid and taken this cycle.
REQ-011 finish  output  1  one-cycle strobe after the fifth digit.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 LEDR  output  4  current state encoding.
REQ-014 HEX0..HEX4  output  7 each  active-low 7-segment display of digits 4..0; HEX4 is the first digit.

Function
REQ-015 The FSM states SHALL be IDLE=0, DRAW=1, SEND=2, WAIT=3 and FIN=4; LEDR SHALL equal the state at all times.
REQ-016 The LFSR SHALL be 16-bit Galois: next = (lfsr>>1) XOR (lfsr[0] ? 16'hB400 : 0); it advances only on DRAW cycles.
REQ-017 IDLE: on start=1 -> clear digit index to 0, blank HEX0-HEX4 (7'b1111111), go to DRAW; otherwise stay.
REQ-018 IDLE: on seed_load=1 -> lfsr <= (seed==0 ? SEED : seed); with start also high, both take effect in the same cycle.
REQ-019 DRAW: if lfsr[3:0] <= 9 -> latch it as digit[index] and go to SEND; else stay in DRAW (rejection).
REQ-020 DRAW: the LFSR SHALL advance on every DRAW cycle, whether the sample is accepted or rejected.
REQ-021 SEND: num SHALL equal digit[index].
REQ-022 SEND: with ready=1, insert SHALL be 1 for exactly that cycle, the digit SHALL appear on its HEX, and index SHALL increment.
REQ-023 SEND exit after an accepted transfer: go to FIN if index was 4; else go to WAIT, or to DRAW when GAP=0.
REQ-024 SEND with ready=0: insert SHALL stay 0 and the state SHALL hold indefinitely, with no timeout.
REQ-025 WAIT: count GAP cycles, then go to DRAW.
REQ-026 FIN: finish=1 for one cycle, then return to IDLE.
REQ-027 insert and finish SHALL never be high in the same cycle.
REQ-028 num and HEX0-HEX4 SHALL hold their last values in IDLE until the next start.
REQ-029 start, seed_load and seed SHALL be ignored outside IDLE; a start pulse mid-draw SHALL have no effect.
REQ-030 HEX encoding SHALL be active-low gfedcba: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-031 The digit index SHALL be 3 bits and never exceed 4.

Reset
REQ-032 Asserting reset SHALL immediately, regardless of clk, set: state=IDLE, lfsr=SEED, index=0, digits=0, num=0, insert=0, finish=0, busy=0, LEDR=0, HEX0-HEX4=1111111.
REQ-033 Reset asserted mid-draw SHALL abort the draw with no further insert or finish strobe; the first post-reset start SHALL reproduce the SEED sequence.

Verification
REQ-034 Default SEED, ready=1, start pulse -> digits 1,0,8,7,3 on five insert strobes, two rejected DRAW cycles (samples C, E) before digit 7, then one finish pulse; HEX4..HEX0 = 1111001,1000000,0000000,1111000,0110000.
REQ-035 seed_load with seed=0 in IDLE, then start -> sequence identical to REQ-034.
REQ-036 ready=0 held for 10 cycles in the first SEND -> insert=0, num=1, LEDR=2 throughout; ready=1 -> exactly one insert.
REQ-037 start pulsed during WAIT -> ignored; exactly five inserts and one finish occur.
REQ-038 reset low during the third SEND -> outputs at reset values with no clk edge; the next start reproduces digits 1,0,8,7,3.
REQ-039 GAP=0 -> DRAW follows SEND directly; insert strobes for digits 0 and 1 are two cycles apart.
